// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART baud/oversample tick generator.
package uart_pkg;

   localparam logic MODE_TX = 1'b0;
   localparam logic MODE_RX = 1'b1;
   localparam int   DIV_MIN = 2;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/configuration and tick bundle between the UART and its baud generator.
interface uart_baud_gen_if
   import uart_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 4,
   parameter int OVS    = 16
) ();

   logic                     enable;
   logic                     mode;
   logic [DIV_W-1:0]         cfg_div_int;
   logic [FRAC_W-1:0]        cfg_div_frac;
   logic                     cfg_load;
   logic                     ovs_tick;
   logic                     bit_tick;
   logic                     sample_tick;
   logic [clog2(OVS)-1:0]    phase;
   logic                     cfg_pending;

   modport master (
      output enable, mode, cfg_div_int, cfg_div_frac, cfg_load,
      input  ovs_tick, bit_tick, sample_tick, phase, cfg_pending
   );

   modport slave (
      input  enable, mode, cfg_div_int, cfg_div_frac, cfg_load,
      output ovs_tick, bit_tick, sample_tick, phase, cfg_pending
   );

endinterface

// File: rtl/uart_frac_div.sv
// Fractional period counter: periods of D or D+1 clocks chosen by accumulator carry.
module uart_frac_div
   import uart_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              acc_clr,
   output logic              tick_next,
   output logic              ovs_tick
);

   logic              running;
   logic [DIV_W:0]    cnt;
   logic [FRAC_W-1:0] acc;
   logic [DIV_W-1:0]  d_eff;
   logic [FRAC_W-1:0] acc_base;
   logic [FRAC_W:0]   acc_sum;
   logic [DIV_W:0]    period;

   assign d_eff     = (div_int < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_int;
   assign acc_base  = acc_clr ? '0 : acc;
   assign acc_sum   = {1'b0, acc_base} + {1'b0, div_frac};
   assign period    = {1'b0, d_eff} + (DIV_W+1)'(acc_sum[FRAC_W]);
   // tick_next flags the edge that ends the current period and starts the next
   assign tick_next = running && (cnt == (DIV_W+1)'(1));

   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         running  <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         ovs_tick <= 1'b0;
      end else if (!running || tick_next) begin
         running  <= 1'b1;
         cnt      <= period;
         acc      <= acc_sum[FRAC_W-1:0];
         ovs_tick <= tick_next;
      end else begin
         cnt      <= cnt - (DIV_W+1)'(1);
         ovs_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud/oversample tick generator with runtime fractional divisor and bit-aligned reload.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W        = 16,
   parameter int FRAC_W       = 4,
   parameter int OVS          = 16,
   parameter int DEF_DIV_INT  = 27,
   parameter int DEF_DIV_FRAC = 2
) (
   input logic            clk,
   input logic            reset,
   uart_baud_gen_if.slave bus
);

   localparam int PH_W = clog2(OVS);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic              launch;
   logic [DIV_W-1:0]  act_int, shd_int, div_int_sel;
   logic [FRAC_W-1:0] act_frac, shd_frac, div_frac_sel;
   logic              pending;
   logic [PH_W-1:0]   phase_r;
   logic              bit_r, samp_r;
   logic              tick_next, ovs_tick;
   logic              wrap, apply_now;

   assign wrap         = tick_next && (phase_r == PH_W'(OVS-1));
   // A pending divisor must drive the very period that begins at the bit boundary
   assign apply_now    = (state == RUN) && bus.enable && wrap && pending;
   assign div_int_sel  = apply_now ? shd_int  : act_int;
   assign div_frac_sel = apply_now ? shd_frac : act_frac;

   uart_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_frac_div (
      .clk       (clk),
      .reset     (reset),
      .enable    (bus.enable),
      .div_int   (div_int_sel),
      .div_frac  (div_frac_sel),
      .acc_clr   (apply_now),
      .tick_next (tick_next),
      .ovs_tick  (ovs_tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         launch   <= 1'b0;
         phase_r  <= '0;
         bit_r    <= 1'b0;
         samp_r   <= 1'b0;
         pending  <= 1'b0;
         act_int  <= DIV_W'(DEF_DIV_INT);
         act_frac <= FRAC_W'(DEF_DIV_FRAC);
      end else begin
         case (state)
            IDLE: begin
               phase_r <= '0;
               bit_r   <= 1'b0;
               samp_r  <= 1'b0;
               if (bus.cfg_load) begin
                  act_int  <= bus.cfg_div_int;
                  act_frac <= bus.cfg_div_frac;
               end
               if (bus.enable) begin
                  state  <= RUN;
                  launch <= (bus.mode == MODE_TX);
               end
            end
            RUN: begin
               if (!bus.enable) begin
                  state   <= IDLE;
                  launch  <= 1'b0;
                  phase_r <= '0;
                  bit_r   <= 1'b0;
                  samp_r  <= 1'b0;
                  pending <= 1'b0;
                  if (bus.cfg_load) begin
                     act_int  <= bus.cfg_div_int;
                     act_frac <= bus.cfg_div_frac;
                  end else if (pending) begin
                     act_int  <= shd_int;
                     act_frac <= shd_frac;
                  end
               end else begin
                  launch <= 1'b0;
                  bit_r  <= launch || wrap;
                  samp_r <= tick_next && (phase_r == PH_W'(OVS/2-1));
                  if (tick_next) phase_r <= phase_r + PH_W'(1);
                  if (apply_now) begin
                     act_int  <= shd_int;
                     act_frac <= shd_frac;
                     pending  <= 1'b0;
                  end
                  // A load on the applying edge lands in the shadow and stays pending
                  if (bus.cfg_load) begin
                     shd_int  <= bus.cfg_div_int;
                     shd_frac <= bus.cfg_div_frac;
                     pending  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ovs_tick    = ovs_tick;
   assign bus.bit_tick    = bit_r;
   assign bus.sample_tick = samp_r;
   assign bus.phase       = phase_r;
   assign bus.cfg_pending = pending;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench: tick times from the closed form T_k = k*D + floor(k*frac/16).
module tb_uart_baud_gen;
   import uart_pkg::*;

   localparam int DIV_W  = 16;
   localparam int FRAC_W = 4;
   localparam int OVS    = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) bus ();

   uart_baud_gen #(
      .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS),
      .DEF_DIV_INT(27), .DEF_DIV_FRAC(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int c, input int e_ovs, input int e_bit,
                            input int e_samp, input int e_phase);
      check($sformatf("%s ovs c=%0d", tag, c), int'(bus.ovs_tick), e_ovs);
      check($sformatf("%s bit c=%0d", tag, c), int'(bus.bit_tick), e_bit);
      check($sformatf("%s samp c=%0d", tag, c), int'(bus.sample_tick), e_samp);
      check($sformatf("%s phase c=%0d", tag, c), int'(bus.phase), e_phase);
   endtask

   task automatic load_idle(input int di, input int df);
      bus.cfg_div_int  = DIV_W'(di);
      bus.cfg_div_frac = FRAC_W'(df);
      bus.cfg_load     = 1'b1;
      step();
      bus.cfg_load     = 1'b0;
      check("idle_load_pending", int'(bus.cfg_pending), 0);
   endtask

   task automatic start_run(input int md);
      bus.mode   = md[0];
      bus.enable = 1'b1;
      step();
   endtask

   task automatic stop_check(input string tag);
      bus.enable = 1'b0;
      step();
      check_all(tag, 0, 0, 0, 0, 0);
      check({tag, " pending"}, int'(bus.cfg_pending), 0);
   endtask

   // Runs n cycles after the enable edge; expectations come from the closed-form tick times
   task automatic run_model(input string tag, input int di, input int df, input int md,
                            input int n, input bit toggle, output int ovs72, output int bits);
      int d, k, nt, t_next, e_ovs, e_bit, e_samp;
      d = (di < DIV_MIN) ? DIV_MIN : di;
      k = 1;
      nt = 0;
      ovs72 = 0;
      bits = 0;
      start_run(md);
      for (int c = 1; c <= n; c++) begin
         step();
         t_next = k * d + ((k * df) >> FRAC_W);
         e_ovs  = (c == t_next) ? 1 : 0;
         if (e_ovs == 1) begin
            nt++;
            k++;
         end
         e_bit  = ((e_ovs == 1 && nt % OVS == 0) || (c == 1 && md == 0)) ? 1 : 0;
         e_samp = (e_ovs == 1 && nt % OVS == OVS/2) ? 1 : 0;
         check_all(tag, c, e_ovs, e_bit, e_samp, nt % OVS);
         if (c <= 72 && bus.ovs_tick) ovs72++;
         if (bus.bit_tick) bits++;
         if (toggle) bus.mode = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      int o72, nb, di, df, md, e_ovs, e_bit, e_pend, e_phase;
      checks = 0;
      errors = 0;
      reset = 1'b0;
      bus.enable = 1'b0;
      bus.mode = MODE_TX;
      bus.cfg_div_int = '0;
      bus.cfg_div_frac = '0;
      bus.cfg_load = 1'b0;
      repeat (3) step();
      check_all("reset", 0, 0, 0, 0, 0);
      check("reset pending", int'(bus.cfg_pending), 0);
      reset = 1'b1;
      step();

      // default divisor 27/2: first tick at 27, 8th period is 28 cycles
      run_model("def", 27, 2, 0, 260, 1'b0, o72, nb);
      stop_check("def_stop");

      load_idle(4, 0);
      run_model("rx4", 4, 0, 1, 40, 1'b0, o72, nb);
      stop_check("rx4_stop");
      run_model("tx4", 4, 0, 0, 40, 1'b0, o72, nb);
      stop_check("tx4_stop");

      load_idle(4, 8);
      run_model("frac", 4, 8, 1, 18000, 1'b0, o72, nb);
      check("frac ovs_in_72", o72, 16);
      check("frac bits_1000", nb, 1000);
      stop_check("frac_stop");

      load_idle(1, 0);
      run_model("clamp1", 1, 0, 0, 20, 1'b0, o72, nb);
      stop_check("clamp1_stop");
      load_idle(0, 0);
      run_model("clamp0", 0, 0, 1, 20, 1'b0, o72, nb);
      stop_check("clamp0_stop");

      repeat (6) begin
         di = $urandom_range(0, 10);
         df = $urandom_range(0, 15);
         md = $urandom_range(0, 1);
         load_idle(di, df);
         run_model("rand", di, df, md, 150, 1'b1, o72, nb);
         stop_check("rand_stop");
      end

      // reload during RUN takes effect at the next bit boundary (cycle 16)
      load_idle(4, 0);
      start_run(0);
      for (int c = 1; c <= 48; c++) begin
         step();
         e_ovs   = (c <= 16) ? ((c % 4 == 0) ? 1 : 0) : (((c - 16) % 8 == 0) ? 1 : 0);
         e_bit   = (c == 1 || c == 16 || c == 48) ? 1 : 0;
         e_pend  = (c >= 5 && c < 16) ? 1 : 0;
         e_phase = (c < 16) ? ((c / 4) % 4) : (((c - 16) / 8) % 4);
         check_all("reload", c, e_ovs, e_bit, (c == 8 || c == 32) ? 1 : 0, e_phase);
         check($sformatf("reload pending c=%0d", c), int'(bus.cfg_pending), e_pend);
         if (c == 4) begin
            bus.cfg_div_int  = 16'd8;
            bus.cfg_div_frac = 4'd0;
            bus.cfg_load     = 1'b1;
         end
         if (c == 5) bus.cfg_load = 1'b0;
      end
      stop_check("reload_stop");
      run_model("after_reload", 8, 0, 1, 40, 1'b0, o72, nb);
      stop_check("after_reload_stop");

      // enable drop at phase 2 with a pending shadow: shadow becomes active in IDLE
      load_idle(4, 0);
      start_run(1);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 6) begin
            bus.cfg_div_int  = 16'd3;
            bus.cfg_div_frac = 4'd5;
            bus.cfg_load     = 1'b1;
         end
         if (c == 7) begin
            bus.cfg_load = 1'b0;
            check("drop pending", int'(bus.cfg_pending), 1);
         end
      end
      check("drop phase_before", int'(bus.phase), 2);
      stop_check("drop_stop");
      run_model("after_drop", 3, 5, 0, 60, 1'b0, o72, nb);
      stop_check("after_drop_stop");

      // reset mid-bit discards the pending shadow and restores 27/2
      load_idle(4, 0);
      start_run(0);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 5) begin
            bus.cfg_div_int  = 16'd9;
            bus.cfg_div_frac = 4'd0;
            bus.cfg_load     = 1'b1;
         end
         if (c == 6) bus.cfg_load = 1'b0;
      end
      check("rst pending_before", int'(bus.cfg_pending), 1);
      reset = 1'b0;
      bus.enable = 1'b0;
      step();
      check_all("rst_mid", 0, 0, 0, 0, 0);
      check("rst_mid pending", int'(bus.cfg_pending), 0);
      reset = 1'b1;
      step();
      run_model("after_rst", 27, 2, 1, 60, 1'b0, o72, nb);
      stop_check("after_rst_stop");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
